// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, masters the imem req/ack port and buffers fetched words for decode.
// Build option: define SINGLE_STEP_EN to add a step input that fetches one word per pulse.
//
// state | meaning
// IDLE  | no memory request outstanding
// REQ   | imem_req high at imem_addr, holding until imem_ack
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_pop, count_after;
  logic              push, flush, pop, empty, fetch_more, step_ok;

  logic [INSTR_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0]  mem_pc   [DEPTH];

`ifdef SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  assign step_ok = step;
`else
  localparam bit STEP_MODE = 1'b0;
  assign step_ok = 1'b1;
`endif

  assign empty       = (count_q == '0);
  assign pop         = !empty && instr_ready;
  assign count_pop   = pop ? count_q - CW'(1) : count_q;
  assign count_after = count_pop + CW'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    flush      = 1'b0;
    fetch_more = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      pc_d  = new_pc;
      // an unanswered request must still be held; its data is dropped when it lands
      if (state_q == REQ && !imem_ack) begin
        drop_d = 1'b1;
      end else begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (run && step_ok && count_q < FULL) begin
            state_d = REQ;
            addr_d  = pc_q;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (drop_q) begin
              drop_d     = 1'b0;
              addr_d     = pc_q;
              fetch_more = run && (count_pop < FULL);
            end else begin
              push       = 1'b1;
              pc_d       = pc_q + ADDR_W'(1);
              addr_d     = pc_q + ADDR_W'(1);
              fetch_more = run && (count_after < FULL);
            end
            state_d = (fetch_more && !STEP_MODE) ? REQ : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      drop_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // storage needs no reset: entries are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= pc_q;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign instr_valid = !empty;
  assign instr       = empty ? '0 : mem_data[rd_ptr_q];
  assign instr_pc    = empty ? '0 : mem_pc[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: random memory latency, backpressure and redirects checked
// against a queue-based model of the fetched instruction stream.
module tb_instr_fetch;

  localparam int         AW    = 8;
  localparam int         IW    = 16;
  localparam int         DEPTH = 2;
  localparam logic [7:0] RPC   = 8'h00;

  logic          clk, rst, run, redirect, imem_ack, instr_ready, step;
  logic [AW-1:0] new_pc, imem_addr, instr_pc, pc;
  logic [IW-1:0] imem_rdata, instr;
  logic          imem_req, instr_valid;

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .redirect(redirect), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] d; logic [AW-1:0] a; } ent_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [IW-1:0] mem [256];
  ent_t        q[$];
  logic [AW-1:0] m_pc;
  bit          drop;
  logic [AW-1:0] drop_addr;
  int          n_req, n_push, n_pop;

  task automatic model_reset();
    q.delete();
    m_pc = RPC;
    drop = 1'b0;
    drop_addr = '0;
  endtask

  // One clock: observe outputs at negedge, compare with the model, drive inputs, advance model.
  task automatic cycle(input bit c_run, input bit c_ready, input int ack_pct,
                       input bit c_redir, input logic [AW-1:0] c_newpc, input bit c_step);
    logic [AW-1:0] exp_addr;
    bit do_ack;
    @(negedge clk);
    vectors++;
    if (instr_valid !== (q.size() != 0)) begin
      miscompares++;
      $display("FAIL valid: got %0b want %0b", instr_valid, q.size() != 0);
    end
    vectors++;
    if (q.size() != 0) begin
      if (instr !== q[0].d || instr_pc !== q[0].a) begin
        miscompares++;
        $display("FAIL head: got %h@%h want %h@%h", instr, instr_pc, q[0].d, q[0].a);
      end
    end else if (instr !== 16'h0000) begin
      miscompares++;
      $display("FAIL empty_nop: got %h want 0000", instr);
    end
    vectors++;
    if (pc !== m_pc) begin
      miscompares++;
      $display("FAIL pc: got %h want %h", pc, m_pc);
    end
    exp_addr = drop ? drop_addr : m_pc;
    if (imem_req) begin
      vectors++;
      if (imem_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL imem_addr: got %h want %h", imem_addr, exp_addr);
      end
      if (!drop) begin
        vectors++;
        if (q.size() >= DEPTH) begin
          miscompares++;
          $display("FAIL req_when_full: got size %0d want <%0d", q.size(), DEPTH);
        end
      end
    end
    do_ack      = imem_req && ($urandom_range(99) < ack_pct);
    run         = c_run;
    instr_ready = c_ready;
    redirect    = c_redir;
    new_pc      = c_newpc;
    step        = c_step;
    imem_ack    = do_ack;
    imem_rdata  = do_ack ? mem[imem_addr] : IW'($urandom);
    if (imem_req) n_req++;
    if (q.size() != 0 && c_ready) begin
      void'(q.pop_front());
      if (!c_redir) n_pop++;
    end
    if (c_redir) begin
      q.delete();
      if (imem_req && !do_ack) begin
        if (!drop) drop_addr = exp_addr;
        drop = 1'b1;
      end else begin
        drop = 1'b0;
      end
      m_pc = c_newpc;
    end else if (imem_req && do_ack) begin
      if (drop) drop = 1'b0;
      else begin
        q.push_back('{d: mem[m_pc], a: m_pc});
        m_pc = m_pc + 8'd1;
        n_push++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'($urandom); redirect = 1'($urandom); new_pc = 8'($urandom);
    imem_ack = 1'($urandom); instr_ready = 1'($urandom); imem_rdata = 16'($urandom);
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got req=%0b valid=%0b want 0 0", imem_req, instr_valid);
    end
    vectors++;
    if (instr !== 16'h0 || instr_pc !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_instr: got %h@%h want 0000@00", instr, instr_pc);
    end
    vectors++;
    if (pc !== RPC || imem_addr !== RPC) begin
      miscompares++;
      $display("FAIL reset_pc: got pc=%h addr=%h want %h", pc, imem_addr, RPC);
    end
    rst = 1'b0; run = 1'b0; redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) + 16'h0040;
    test_reset();
    for (int i = 0; i < 40; i++) cycle(1, 1, 100, 0, 8'h00, 1);
  endtask

  task automatic test_backpressure();
    test_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 100, 0, 8'h00, 1);
    @(negedge clk);
    imem_ack = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || instr !== 16'h0040) begin
      miscompares++;
      $display("FAIL full_stall: got req=%0b instr=%h want req=0 instr=0040", imem_req, instr);
    end
    for (int i = 0; i < 12; i++) cycle(1, 1, 100, 0, 8'h00, 1);
  endtask

  task automatic test_delayed_ack();
    for (int i = 0; i < 150; i++) cycle(1, 1'($urandom), 25, 0, 8'h00, 1);
  endtask

  task automatic test_redirect();
    test_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 100, 0, 8'h00, 1);
    cycle(1, 1, 0, 1, 8'h20, 1);
    cycle(1, 1, 0, 0, 8'h00, 1);
    cycle(1, 1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 100, 0, 8'h00, 1);
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(9) != 0, 1'($urandom), 50, $urandom_range(7) == 0, 8'($urandom), 1);
  endtask

  task automatic test_wrap();
    test_reset();
    cycle(0, 1, 100, 1, 8'hFC, 1);
    for (int i = 0; i < 12; i++) cycle(1, 1, 100, 0, 8'h00, 1);
  endtask

  task automatic test_reset_mid_req();
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1, 1, 0, 0, 8'h00, 1);
      if (imem_req) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_req_wait: got no request want imem_req=1 within 10 cycles");
    end
    test_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(15) != 0, $urandom_range(3) != 0, $urandom_range(100),
            $urandom_range(31) == 0, 8'($urandom), 1);
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    test_reset();
    n_req = 0; n_push = 0; n_pop = 0;
    for (int p = 0; p < 3; p++) begin
      cycle(1, 1, 100, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) cycle(1, 1, 100, 0, 8'h00, 0);
    end
    vectors++;
    if (n_req != 3 || n_push != 3 || n_pop != 3) begin
      miscompares++;
      $display("FAIL single_step: got req=%0d push=%0d pop=%0d want 3 3 3", n_req, n_push, n_pop);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; run = 1'b0; redirect = 1'b0; new_pc = '0; imem_ack = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; step = 1'b0;
    n_req = 0; n_push = 0; n_pop = 0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_delayed_ack();
    test_redirect();
    test_wrap();
    test_reset_mid_req();
    test_random();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
